// File: rtl/ramz_arbiter.sv
// Two-requester arbiter for a 32x32 simple-dual-port block RAM.
// The write port and the read port each run their own round-robin arbiter.
module ramz_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_doutb
);

    logic              wrCand0, wrCand1, rdCand0, rdCand1;
    logic              wrAny, rdAny;
    logic              wrWinId, rdWinId;
    logic [ADDR_W-1:0] wrAddr, rdAddr;
    logic [DATA_W-1:0] wrData;
    logic              hazard, wrGrant, rdGrant;

    logic              wrLast_q, wrLast_d;
    logic              rdLast_q, rdLast_d;
    logic              rdStalled_q, rdStalled_d;
    logic              rdPend_q, rdPend_d;
    logic              rdTag_q, rdTag_d;
    logic [ADDR_W-1:0] addrb_q, addrb_d;

    // Candidate selection: on contention the requester that did not win last time goes first.
    always_comb begin
        wrCand0 = m0_req & m0_we;
        wrCand1 = m1_req & m1_we;
        rdCand0 = m0_req & ~m0_we;
        rdCand1 = m1_req & ~m1_we;

        wrAny = wrCand0 | wrCand1;
        rdAny = rdCand0 | rdCand1;

        if (wrCand0 && wrCand1) begin
            wrWinId = ~wrLast_q;
        end else begin
            wrWinId = wrCand1;
        end

        if (rdCand0 && rdCand1) begin
            rdWinId = ~rdLast_q;
        end else begin
            rdWinId = rdCand1;
        end

        wrAddr = wrWinId ? m1_addr  : m0_addr;
        wrData = wrWinId ? m1_wdata : m0_wdata;
        rdAddr = rdWinId ? m1_addr  : m0_addr;
    end

    // Same-address conflict: the write goes first, but a read that already lost once wins next.
    always_comb begin
        hazard  = wrAny & rdAny & (wrAddr == rdAddr);
        wrGrant = wrAny & ~rst & ~(hazard & rdStalled_q);
        rdGrant = rdAny & ~rst & ~(hazard & ~rdStalled_q);

        wrLast_d = wrGrant ? wrWinId : wrLast_q;
        rdLast_d = rdGrant ? rdWinId : rdLast_q;

        rdStalled_d = rdStalled_q;
        if (rdGrant || !rdAny) begin
            rdStalled_d = 1'b0;
        end else if (hazard) begin
            rdStalled_d = 1'b1;
        end

        rdPend_d = rdGrant;
        rdTag_d  = rdGrant ? rdWinId : rdTag_q;
        addrb_d  = rdGrant ? rdAddr  : addrb_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrLast_q    <= 1'b1;
            rdLast_q    <= 1'b1;
            rdStalled_q <= 1'b0;
            rdPend_q    <= 1'b0;
            rdTag_q     <= 1'b0;
            addrb_q     <= '0;
        end else begin
            wrLast_q    <= wrLast_d;
            rdLast_q    <= rdLast_d;
            rdStalled_q <= rdStalled_d;
            rdPend_q    <= rdPend_d;
            rdTag_q     <= rdTag_d;
            addrb_q     <= addrb_d;
        end
    end

    // A requester is either a write or a read candidate, never both, so the OR is exclusive.
    always_comb begin
        m0_gnt    = (wrGrant & ~wrWinId) | (rdGrant & ~rdWinId);
        m1_gnt    = (wrGrant &  wrWinId) | (rdGrant &  rdWinId);

        ram_wea   = wrGrant;
        ram_addra = wrGrant ? wrAddr : '0;
        ram_dina  = wrGrant ? wrData : '0;
        ram_addrb = addrb_d;

        m0_rvalid = rdPend_q & ~rdTag_q & ~rst;
        m1_rvalid = rdPend_q &  rdTag_q & ~rst;
        rdata     = ram_doutb;
    end

endmodule

// File: tb/tb_ramz_arbiter.sv
// Directed self-checking bench for ramz_arbiter with a behavioural block RAM attached.
module tb_ramz_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0Req, m0We, m1Req, m1We;
    logic [4:0]  m0Addr, m1Addr;
    logic [31:0] m0Wdata, m1Wdata;
    logic        m0Gnt, m1Gnt, m0Rvalid, m1Rvalid;
    logic [31:0] rdata;
    logic        ramWea;
    logic [4:0]  ramAddra, ramAddrb;
    logic [31:0] ramDina, ramDoutb;
    logic [31:0] mem [0:31];

    int vecCount = 0;
    int errCount = 0;

    ramz_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
        .m0_gnt(m0Gnt), .m0_rvalid(m0Rvalid),
        .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata),
        .m1_gnt(m1Gnt), .m1_rvalid(m1Rvalid),
        .rdata(rdata),
        .ram_wea(ramWea), .ram_addra(ramAddra), .ram_dina(ramDina),
        .ram_addrb(ramAddrb), .ram_doutb(ramDoutb)
    );

    always #5 clk = ~clk;

    // Simple-dual-port RAM with a registered read port
    always @(posedge clk) begin
        if (ramWea) mem[ramAddra] <= ramDina;
        ramDoutb <= mem[ramAddrb];
    end

    task automatic applyStimulus(input logic r0, input logic w0, input logic [4:0] a0,
                                 input logic [31:0] d0, input logic r1, input logic w1,
                                 input logic [4:0] a1, input logic [31:0] d1);
        m0Req = r0; m0We = w0; m0Addr = a0; m0Wdata = d0;
        m1Req = r1; m1We = w1; m1Addr = a1; m1Wdata = d1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checkOutput("rstGnt0", {31'd0, m0Gnt}, 0);
        checkOutput("rstWea", {31'd0, ramWea}, 0);
        checkOutput("rstRv0", {31'd0, m0Rvalid}, 0);

        // Lone write then read of the same address
        @(negedge clk); rst = 1'b0;
        applyStimulus(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0); #1;
        checkOutput("w1Gnt0", {31'd0, m0Gnt}, 1);
        checkOutput("w1Wea", {31'd0, ramWea}, 1);
        checkOutput("w1Addra", {27'd0, ramAddra}, 5);
        checkOutput("w1Dina", ramDina, 32'hDEADBEEF);
        @(negedge clk);
        applyStimulus(1, 0, 5, 0, 0, 0, 0, 0); #1;
        checkOutput("r1Gnt0", {31'd0, m0Gnt}, 1);
        checkOutput("r1Addrb", {27'd0, ramAddrb}, 5);
        checkOutput("r1WeaOff", {31'd0, ramWea}, 0);
        checkOutput("r1AddraIdle", {27'd0, ramAddra}, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("r1Rv0", {31'd0, m0Rvalid}, 1);
        checkOutput("r1Rv1", {31'd0, m1Rvalid}, 0);
        checkOutput("r1Data", rdata, 32'hDEADBEEF);
        @(negedge clk); #1;
        checkOutput("r1RvPulse", {31'd0, m0Rvalid}, 0);

        // Write contention after a fresh reset: m0 first, then alternating
        rst = 1'b1; #1; rst = 1'b0;
        @(negedge clk);
        applyStimulus(1, 1, 1, 32'h100, 1, 1, 2, 32'h200); #1;
        checkOutput("wc0Gnt0", {31'd0, m0Gnt}, 1);
        checkOutput("wc0Gnt1", {31'd0, m1Gnt}, 0);
        @(negedge clk);
        applyStimulus(1, 1, 1, 32'h101, 1, 1, 2, 32'h200); #1;
        checkOutput("wc1Gnt0", {31'd0, m0Gnt}, 0);
        checkOutput("wc1Gnt1", {31'd0, m1Gnt}, 1);
        @(negedge clk);
        applyStimulus(1, 1, 1, 32'h101, 1, 1, 2, 32'h201); #1;
        checkOutput("wc2Gnt0", {31'd0, m0Gnt}, 1);
        checkOutput("wc2Gnt1", {31'd0, m1Gnt}, 0);
        @(negedge clk);
        applyStimulus(1, 1, 1, 32'h102, 1, 1, 2, 32'h201); #1;
        checkOutput("wc3Gnt0", {31'd0, m0Gnt}, 0);
        checkOutput("wc3Gnt1", {31'd0, m1Gnt}, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("wcMem1", mem[1], 32'h101);
        checkOutput("wcMem2", mem[2], 32'h201);

        // Same-address hazard: write first, then the stalled read wins
        @(negedge clk);
        applyStimulus(1, 1, 7, 32'h7001, 1, 0, 7, 0); #1;
        checkOutput("hz1Gnt0", {31'd0, m0Gnt}, 1);
        checkOutput("hz1Gnt1", {31'd0, m1Gnt}, 0);
        @(negedge clk);
        applyStimulus(1, 1, 7, 32'h7002, 1, 0, 7, 0); #1;
        checkOutput("hz2Gnt0", {31'd0, m0Gnt}, 0);
        checkOutput("hz2Gnt1", {31'd0, m1Gnt}, 1);
        checkOutput("hz2Wea", {31'd0, ramWea}, 0);
        @(negedge clk);
        applyStimulus(1, 1, 7, 32'h7002, 0, 0, 0, 0); #1;
        checkOutput("hz3Rv1", {31'd0, m1Rvalid}, 1);
        checkOutput("hz3Data", rdata, 32'h7001);
        checkOutput("hz3Gnt0", {31'd0, m0Gnt}, 1);

        // Read and write at different addresses in the same cycle
        @(negedge clk);
        applyStimulus(1, 1, 3, 32'h33333333, 0, 0, 0, 0); #1;
        checkOutput("pre3Gnt0", {31'd0, m0Gnt}, 1);
        @(negedge clk);
        applyStimulus(1, 0, 3, 0, 1, 1, 4, 32'h12345678); #1;
        checkOutput("rwGnt0", {31'd0, m0Gnt}, 1);
        checkOutput("rwGnt1", {31'd0, m1Gnt}, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("rwRv0", {31'd0, m0Rvalid}, 1);
        checkOutput("rwData", rdata, 32'h33333333);
        checkOutput("rwMem4", mem[4], 32'h12345678);

        // Back-to-back reads m0@1, m1@2, m0@3
        @(negedge clk);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0); #1;
        checkOutput("bbGntA", {31'd0, m0Gnt}, 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1, 0, 2, 0); #1;
        checkOutput("bbGntB", {31'd0, m1Gnt}, 1);
        checkOutput("bbRvA", {30'd0, m1Rvalid, m0Rvalid}, 32'h1);
        checkOutput("bbDataA", rdata, 32'h101);
        @(negedge clk);
        applyStimulus(1, 0, 3, 0, 0, 0, 0, 0); #1;
        checkOutput("bbRvB", {30'd0, m1Rvalid, m0Rvalid}, 32'h2);
        checkOutput("bbDataB", rdata, 32'h201);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
        checkOutput("bbRvC", {30'd0, m1Rvalid, m0Rvalid}, 32'h1);
        checkOutput("bbDataC", rdata, 32'h33333333);

        // Asynchronous reset right after a read grant kills the pending rvalid
        @(negedge clk);
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0); #1;
        checkOutput("arGnt0", {31'd0, m0Gnt}, 1);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        checkOutput("arRv0", {31'd0, m0Rvalid}, 0);
        checkOutput("arGntOff", {31'd0, m0Gnt}, 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 0, 1, 0, 1, 0, 2, 0); #1;
        checkOutput("arRdCont0", {31'd0, m0Gnt}, 1);
        checkOutput("arRdCont1", {31'd0, m1Gnt}, 0);
        @(negedge clk);
        applyStimulus(1, 1, 10, 32'hA, 1, 1, 11, 32'hB); #1;
        checkOutput("arRvAfter", {31'd0, m0Rvalid}, 1);
        checkOutput("arWrCont0", {31'd0, m0Gnt}, 1);
        checkOutput("arWrCont1", {31'd0, m1Gnt}, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule
